// File: rtl/mul_err_sweep.sv
// mul_err_sweep: exhaustive error sweep of an approximate 2x2 multiplier netlist
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a sweep (honoured only while idle)
//   apx_in   out  vector to the netlist, a = [1:0], b = [3:2]
//   apx_out  in   combinational netlist product for apx_in
//   busy     out  high during SWEEP and DRAIN
//   done     out  one-cycle pulse when the results are final
//   max_err  out  largest absolute error seen
//   err_sum  out  sum of absolute errors
//   err_cnt  out  number of vectors with a nonzero error
//   fail     out  some error exceeded ET
//
// Optional build macro MUL_ERR_EARLY_ABORT_EN: end the sweep right after the
// first sample whose error exceeds ET.
module mul_err_sweep #(
    parameter logic [7:0] ET = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] apx_in,
    input  logic [3:0] apx_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] max_err,
    output logic [7:0] err_sum,
    output logic [4:0] err_cnt,
    output logic       fail
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] apx_in_q, apx_in_d;
    logic [3:0] v_q, v_d;
    logic [3:0] o_q, o_d;
    logic       smp_q, smp_d;
    logic [3:0] max_q, max_d;
    logic [7:0] sum_q, sum_d;
    logic [4:0] cnt_q, cnt_d;
    logic       fail_q, fail_d;
    logic [3:0] exact;
    logic [4:0] diff;
    logic [3:0] err;
    logic       acc;
    logic       over;

    always_comb begin
        exact    = 4'({2'b00, v_q[1:0]} * {2'b00, v_q[3:2]});
        diff     = {1'b0, exact} - {1'b0, o_q};
        err      = diff[4] ? 4'(-diff) : diff[3:0];
        // v_q/o_q hold a valid sample only one cycle after a SWEEP cycle,
        // and samples arriving after an abort into DONE are discarded
        acc      = smp_q && (state_q == S_SWEEP || state_q == S_DRAIN);
        over     = acc && ({4'b0000, err} > ET);
        state_d  = state_q;
        apx_in_d = apx_in_q;
        max_d    = max_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        v_d      = apx_in_q;
        o_d      = apx_out;
        smp_d    = state_q == S_SWEEP;
        if (state_q == S_IDLE && start) begin
            state_d  = S_SWEEP;
            apx_in_d = 4'd0;
            max_d    = 4'd0;
            sum_d    = 8'd0;
            cnt_d    = 5'd0;
            fail_d   = 1'b0;
        end else if (state_q == S_SWEEP) begin
            state_d  = apx_in_q == 4'd15 ? S_DRAIN : S_SWEEP;
            apx_in_d = apx_in_q == 4'd15 ? apx_in_q : apx_in_q + 4'd1;
        end else if (state_q == S_DRAIN) begin
            state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
        if (acc) begin
            max_d  = err > max_q ? err : max_q;
            sum_d  = sum_q + {4'b0000, err};
            cnt_d  = cnt_q + {4'b0000, err != 4'd0};
            fail_d = fail_q | over;
        end
`ifdef MUL_ERR_EARLY_ABORT_EN
        if (over) begin
            state_d  = S_DONE;
            apx_in_d = apx_in_q;
        end
`else
        smp_d = smp_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            apx_in_q <= 4'd0;
            v_q      <= 4'd0;
            o_q      <= 4'd0;
            smp_q    <= 1'b0;
            max_q    <= 4'd0;
            sum_q    <= 8'd0;
            cnt_q    <= 5'd0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            apx_in_q <= apx_in_d;
            v_q      <= v_d;
            o_q      <= o_d;
            smp_q    <= smp_d;
            max_q    <= max_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
        end
    end

    assign apx_in  = apx_in_q;
    assign busy    = state_q == S_SWEEP || state_q == S_DRAIN;
    assign done    = state_q == S_DONE;
    assign max_err = max_q;
    assign err_sum = sum_q;
    assign err_cnt = cnt_q;
    assign fail    = fail_q;
endmodule

// File: tb/tb_mul_err_sweep.sv
// tb_mul_err_sweep: directed table-driven bench for mul_err_sweep
module tb_mul_err_sweep;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st0 = 1'b0;
    logic       st1 = 1'b0;
    logic [1:0] mode = 2'd0;
    int         sel = 0;
    logic [3:0] ai0, ai1, ao0, ao1, mx0, mx1;
    logic       bz0, bz1, dn0, dn1, fl0, fl1;
    logic [7:0] sm0, sm1;
    logic [4:0] cn0, cn1;
    logic [3:0] s_ai, s_mx;
    logic       s_bz, s_dn, s_fl;
    logic [7:0] s_sm;
    logic [4:0] s_cn;
    int         n_vec = 0;
    int         n_bad = 0;
    int         dc[$];
    int         r_mx, r_sm, r_cn, r_fl, r_ai;

    typedef struct {
        int mode; int inst; int dcyc; int mx; int sm; int cn; int fl; int ai;
    } vec_t;
    vec_t tv[4];

    always #5 clk = ~clk;

    // netlist stand-ins: 0 exact, 1 approximate 4+2*(~in3&~in0), 2 stuck-at-zero
    function automatic logic [3:0] model(input logic [1:0] m, input logic [3:0] x);
        return m == 2'd0 ? 4'({2'b00, x[1:0]} * {2'b00, x[3:2]}) :
               m == 2'd1 ? (4'd4 + ((~x[3] & ~x[0]) ? 4'd2 : 4'd0)) : 4'd0;
    endfunction

    assign ao0 = model(mode, ai0);
    assign ao1 = model(mode, ai1);

    mul_err_sweep #(.ET(8'd8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .apx_in(ai0), .apx_out(ao0),
        .busy(bz0), .done(dn0), .max_err(mx0), .err_sum(sm0), .err_cnt(cn0), .fail(fl0)
    );

    mul_err_sweep #(.ET(8'd4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .apx_in(ai1), .apx_out(ao1),
        .busy(bz1), .done(dn1), .max_err(mx1), .err_sum(sm1), .err_cnt(cn1), .fail(fl1)
    );

    always_comb begin
        s_ai = sel != 0 ? ai1 : ai0;
        s_bz = sel != 0 ? bz1 : bz0;
        s_dn = sel != 0 ? dn1 : dn0;
        s_mx = sel != 0 ? mx1 : mx0;
        s_sm = sel != 0 ? sm1 : sm0;
        s_cn = sel != 0 ? cn1 : cn0;
        s_fl = sel != 0 ? fl1 : fl0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_st(input logic v);
        if (sel != 0) st1 = v; else st0 = v;
    endtask

    // start sampled at edge 0 and held for `hold` edges; cycle n is observed #1 after edge n-1
    task automatic run(input int hold, input int limit);
        dc.delete();
        @(negedge clk);
        set_st(1'b1);
        @(posedge clk);
        for (int n = 1; n <= limit; n++) begin
            #1;
            if (n == 1) begin
                chk("busy_c1", int'(s_bz), 1);
                chk("apx_in_c1", int'(s_ai), 0);
            end
            if (s_dn) begin
                if (dc.size() == 0) begin
                    r_mx = int'(s_mx); r_sm = int'(s_sm); r_cn = int'(s_cn);
                    r_fl = int'(s_fl); r_ai = int'(s_ai);
                    chk("busy_at_done", int'(s_bz), 0);
                end
                dc.push_back(n);
            end
            set_st(n < hold);
            @(posedge clk);
        end
        set_st(1'b0);
    endtask

    initial begin
        tv[0] = '{0, 0, 18, 0, 0, 0, 0, 15};
        tv[1] = '{1, 0, 18, 6, 54, 15, 0, 15};
        tv[2] = '{2, 0, 18, 9, 36, 9, 1, 15};
`ifdef MUL_ERR_EARLY_ABORT_EN
        tv[3] = '{2, 1, 14, 6, 18, 6, 1, 12};
`else
        tv[3] = '{2, 1, 18, 9, 36, 9, 1, 15};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u0", int'({ai0, bz0, dn0, mx0, sm0, cn0, fl0}), 0);
        chk("rst_u1", int'({ai1, bz1, dn1, mx1, sm1, cn1, fl1}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            mode = 2'(tv[i].mode);
            sel  = tv[i].inst;
            run(1, 25);
            chk($sformatf("v%0d_ndone", i), dc.size(), 1);
            chk($sformatf("v%0d_dcyc", i), dc.size() > 0 ? dc[0] : -1, tv[i].dcyc);
            chk($sformatf("v%0d_max", i), r_mx, tv[i].mx);
            chk($sformatf("v%0d_sum", i), r_sm, tv[i].sm);
            chk($sformatf("v%0d_cnt", i), r_cn, tv[i].cn);
            chk($sformatf("v%0d_fail", i), r_fl, tv[i].fl);
            chk($sformatf("v%0d_apx_in", i), r_ai, tv[i].ai);
            chk($sformatf("v%0d_hold_sum", i), int'(s_sm), tv[i].sm);
        end

        // reset at cycle 8 of a stuck-at-zero sweep: vectors 0..5 are in, sum 1
        sel  = 0;
        mode = 2'd2;
        @(negedge clk);
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_sum", int'(sm0), 1);
        chk("pre_rst_busy", int'(bz0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_all", int'({ai0, bz0, dn0, mx0, sm0, cn0, fl0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd;
            nd = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (dn0) nd++;
            end
            chk("no_done_after_rst", nd, 0);
        end
        run(1, 25);
        chk("post_rst_dcyc", dc.size() > 0 ? dc[0] : -1, 18);
        chk("post_rst_sum", r_sm, 36);

        // start held across cycles 0..20
        mode = 2'd0;
        run(21, 45);
        chk("held_ndone", dc.size(), 2);
        chk("held_d1", dc.size() > 0 ? dc[0] : -1, 18);
        chk("held_d2", dc.size() > 1 ? dc[1] : -1, 37);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
